// File: rtl/sub_seq_pkg.sv
// Shared types and defaults for the subtraction operand sequencer.
// Holds the FSM state encoding, default sweep bounds and a saturating counter helper.
package sub_seq_pkg;

    localparam int OP_W_DEF    = 5;
    localparam int MIN_VAL_DEF = 1;
    localparam int MAX_VAL_DEF = 15;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sub_seq_checker.sv
// Compares each returned difference against the expected a-b and keeps a
// saturating count of mismatches for the current sweep.
module sub_seq_checker
    import sub_seq_pkg::*;
#(
    parameter int OP_W = OP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             check,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    input  logic [OP_W:0]    res_d,
    output logic [CNT_W-1:0] err_count
);

    logic [OP_W:0] expected;

    // Zero-extend before subtracting so the borrow lands in the extra bit.
    assign expected = {1'b0, a} - {1'b0, b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clear) begin
            err_count <= '0;
        end else if (check && (res_d != expected)) begin
            err_count <= sat_inc(err_count);
        end
    end

endmodule

// File: rtl/sub_operand_sequencer.sv
// Sweeps every (a,b) pair in [MIN_VAL,MAX_VAL]^2, issues the pairs with a>=b to a
// downstream subtractor one at a time, and checks each returned difference.
module sub_operand_sequencer
    import sub_seq_pkg::*;
#(
    parameter int OP_W    = OP_W_DEF,
    parameter int MIN_VAL = MIN_VAL_DEF,
    parameter int MAX_VAL = MAX_VAL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [OP_W-1:0]  op_a,
    output logic [OP_W-1:0]  op_b,
    output logic             op_valid,
    input  logic             op_ready,
    input  logic [OP_W:0]    res_d,
    input  logic             res_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pair_count,
    output logic [CNT_W-1:0] err_count,
    output seq_state_e       state_dbg
);

    localparam logic [OP_W-1:0] MIN_L = OP_W'(MIN_VAL);
    localparam logic [OP_W-1:0] MAX_L = OP_W'(MAX_VAL);

    seq_state_e      state;
    logic [OP_W-1:0] a, b;
    logic [OP_W-1:0] a_nxt, b_nxt;
    logic            last_pair;
    logic            advance;
    logic            sweep_start;
    logic            check_en;

    // Handshake: a pair transfers on any edge where op_valid && op_ready; once
    // op_valid rises, op_a/op_b/op_valid hold until that transfer. A result is
    // consumed only in ST_WAIT on an edge where res_valid is high.
    always_comb begin
        a_nxt     = a;
        b_nxt     = b + OP_W'(1);
        if (b == MAX_L) begin
            a_nxt = a + OP_W'(1);
            b_nxt = MIN_L;
        end
        last_pair   = (a == MAX_L) && (b == MAX_L);
        advance     = ((state == ST_ISSUE) && (a < b)) ||
                      ((state == ST_WAIT) && res_valid);
        sweep_start = (state == ST_IDLE) && start;
        check_en    = (state == ST_WAIT) && res_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            a          <= '0;
            b          <= '0;
            op_valid   <= 1'b0;
            done       <= 1'b0;
            pair_count <= '0;
        end else if (advance) begin
            if (last_pair) begin
                state    <= ST_DONE;
                done     <= 1'b1;
                op_valid <= 1'b0;
            end else begin
                state    <= ST_ISSUE;
                a        <= a_nxt;
                b        <= b_nxt;
                op_valid <= (a_nxt >= b_nxt);
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_ISSUE;
                        a          <= MIN_L;
                        b          <= MIN_L;
                        op_valid   <= 1'b1;
                        pair_count <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (op_valid && op_ready) begin
                        state      <= ST_WAIT;
                        op_valid   <= 1'b0;
                        pair_count <= sat_inc(pair_count);
                    end
                end
                ST_WAIT: begin
                    state <= ST_WAIT;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign op_a      = a;
    assign op_b      = b;
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    sub_seq_checker #(
        .OP_W(OP_W)
    ) u_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (sweep_start),
        .check     (check_en),
        .a         (a),
        .b         (b),
        .res_d     (res_d),
        .err_count (err_count)
    );

endmodule

// File: tb/tb_sub_operand_sequencer.sv
// Bench for sub_operand_sequencer: a subtractor model answers each issued pair and
// the observed pair stream is compared with the full sweep enumerated up front.
module tb_sub_operand_sequencer;
    import sub_seq_pkg::*;

    localparam int OP_W    = 5;
    localparam int MIN_VAL = 1;
    localparam int MAX_VAL = 15;
    localparam int RW      = OP_W + 1;
    localparam int PW      = 2 * OP_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             op_ready = 1'b0;
    logic             res_valid = 1'b0;
    logic [RW-1:0]    res_d = '0;
    logic [OP_W-1:0]  op_a, op_b;
    logic             op_valid, busy, done;
    logic [7:0]       pair_count, err_count;
    seq_state_e       state_dbg;

    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] obs_q[$];
    int exp_issue, exp_skip;
    int errors = 0;
    int checks = 0;

    int done_cnt, busy_cycles, fin_pc, fin_ec, stall_seen;
    bit timeout, stall_bad, wait_bad;

    always #5 clk = ~clk;

    sub_operand_sequencer #(
        .OP_W(OP_W), .MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
        .res_d(res_d), .res_valid(res_valid),
        .busy(busy), .done(done), .pair_count(pair_count), .err_count(err_count),
        .state_dbg(state_dbg)
    );

    // Reference sweep: a outer, b inner; only a>=b pairs reach the subtractor.
    task automatic build_model();
        exp_q.delete();
        exp_issue = 0;
        exp_skip = 0;
        for (int ia = MIN_VAL; ia <= MAX_VAL; ia++) begin
            for (int ib = MIN_VAL; ib <= MAX_VAL; ib++) begin
                if (ia >= ib) begin
                    exp_q.push_back({OP_W'(ia), OP_W'(ib)});
                    exp_issue++;
                end else begin
                    exp_skip++;
                end
            end
        end
    endtask

    task automatic run_sweep(input bit rand_mode, input int stall_a, input int stall_b,
                             input int stall_n, input int bad_a, input int bad_b,
                             input int bad_val, input int restart_at, input int stop_at);
        int stall_left, delay, stall_pc;
        bit pend, restarted, finished;
        logic [OP_W-1:0] pa, pb;
        obs_q.delete();
        done_cnt = 0; busy_cycles = 0; fin_pc = -1; fin_ec = -1;
        stall_seen = 0; timeout = 0; stall_bad = 0; wait_bad = 0;
        stall_left = stall_n; pend = 0; restarted = 0; finished = 0;
        delay = 0; stall_pc = 0; pa = '0; pb = '0;
        @(posedge clk); #1;
        start = 1'b1; op_ready = 1'b0; res_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (done) begin
                done_cnt++;
                fin_pc = int'(pair_count);
                fin_ec = int'(err_count);
                finished = 1;
                break;
            end
            if (stop_at >= 0 && obs_q.size() == stop_at) begin
                finished = 1;
                break;
            end
            if (busy) busy_cycles++;
            start = 1'b0;
            if (restart_at >= 0 && !restarted && obs_q.size() == restart_at) begin
                start = 1'b1;
                restarted = 1;
            end
            if (pend) begin
                if (op_valid) wait_bad = 1;
                if (delay == 0) begin
                    res_valid = 1'b1;
                    if (int'(pa) == bad_a && int'(pb) == bad_b) res_d = RW'(bad_val);
                    else res_d = RW'(int'(pa) - int'(pb));
                    pend = 0;
                end else begin
                    res_valid = 1'b0;
                    delay--;
                end
            end else if (rand_mode) begin
                res_valid = 1'($urandom_range(0, 1));
                res_d = RW'(int'(op_a) - int'(op_b) + 1);
            end else begin
                res_valid = 1'b0;
            end
            if (op_valid && int'(op_a) == stall_a && int'(op_b) == stall_b && stall_left > 0) begin
                if (stall_left == stall_n) stall_pc = int'(pair_count);
                else if (int'(pair_count) != stall_pc) stall_bad = 1;
                stall_seen++;
                stall_left--;
                op_ready = 1'b0;
            end else begin
                op_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (op_valid && op_ready) begin
                obs_q.push_back({op_a, op_b});
                pa = op_a;
                pb = op_b;
                pend = 1;
                delay = rand_mode ? int'($urandom_range(0, 2)) : 0;
            end
            @(posedge clk); #1;
        end
        if (!finished) timeout = 1;
        op_ready = 1'b0;
        res_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (op_a !== '0 || op_b !== '0 || op_valid !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || pair_count !== 8'd0 || err_count !== 8'd0 || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: op_a=%0d op_b=%0d v=%b busy=%b done=%b pc=%0d ec=%0d st=%0d, required all 0",
                     op_a, op_b, op_valid, busy, done, pair_count, err_count, state_dbg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_without_start: busy=%b required 0", busy);
        end
    endtask

    task automatic test_basic_sweep();
        int mism;
        build_model();
        run_sweep(0, -1, -1, 0, -1, -1, 0, -1, -1);
        checks++;
        if (timeout) begin errors++; $display("FAIL basic_timeout: no done within budget"); end
        checks++;
        if (obs_q.size() != exp_issue) begin
            errors++;
            $display("FAIL basic_transfers: got %0d required %0d", obs_q.size(), exp_issue);
        end
        mism = 0;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) mism++;
        checks++;
        if (mism != 0) begin errors++; $display("FAIL basic_order: %0d pairs out of order, required 0", mism); end
        checks++;
        if (obs_q.size() == 0 || obs_q[0] !== {OP_W'(MIN_VAL), OP_W'(MIN_VAL)}) begin
            errors++;
            $display("FAIL basic_first_pair: got %h required (1,1)", obs_q.size() ? obs_q[0] : '0);
        end
        checks++;
        if (obs_q.size() == 0 || obs_q[obs_q.size()-1] !== {OP_W'(MAX_VAL), OP_W'(MAX_VAL)}) begin
            errors++;
            $display("FAIL basic_last_pair: got %h required (15,15)", obs_q.size() ? obs_q[obs_q.size()-1] : '0);
        end
        checks++;
        if (fin_pc != 120 || fin_ec != 0) begin
            errors++;
            $display("FAIL basic_counts: pc=%0d ec=%0d required 120/0", fin_pc, fin_ec);
        end
        checks++;
        if (busy_cycles != 2 * exp_issue + exp_skip) begin
            errors++;
            $display("FAIL basic_latency: busy cycles %0d required %0d", busy_cycles, 2 * exp_issue + exp_skip);
        end
        checks++;
        if (wait_bad) begin errors++; $display("FAIL basic_wait_valid: op_valid=1 while result outstanding, required 0"); end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: done=%b busy=%b one cycle later, required 0/0", done, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pair_count !== 8'd120 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL idle_hold: pc=%0d ec=%0d required 120/0", pair_count, err_count);
        end
    endtask

    task automatic test_stall();
        int mism;
        build_model();
        run_sweep(0, 4, 2, 5, -1, -1, 0, -1, -1);
        checks++;
        if (stall_seen != 5 || stall_bad) begin
            errors++;
            $display("FAIL stall_hold: stable cycles %0d (pc moved=%b) required 5 (0)", stall_seen, stall_bad);
        end
        mism = 0;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) mism++;
        checks++;
        if (mism != 0 || obs_q.size() != exp_issue || fin_pc != 120 || timeout) begin
            errors++;
            $display("FAIL stall_sweep: mism=%0d n=%0d pc=%0d to=%b required 0/120/120/0",
                     mism, obs_q.size(), fin_pc, timeout);
        end
    endtask

    task automatic test_bad_result();
        build_model();
        run_sweep(0, -1, -1, 0, 7, 3, 5, -1, -1);
        checks++;
        if (fin_ec != 1 || fin_pc != 120 || timeout) begin
            errors++;
            $display("FAIL bad_result: ec=%0d pc=%0d required 1/120", fin_ec, fin_pc);
        end
    endtask

    task automatic test_restart_ignored();
        int mism;
        build_model();
        run_sweep(0, -1, -1, 0, -1, -1, 0, 10, -1);
        mism = 0;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) mism++;
        checks++;
        if (mism != 0 || obs_q.size() != exp_issue || fin_pc != 120 || done_cnt != 1 || timeout) begin
            errors++;
            $display("FAIL restart_ignored: mism=%0d n=%0d pc=%0d done=%0d required 0/120/120/1",
                     mism, obs_q.size(), fin_pc, done_cnt);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int done_seen;
        build_model();
        run_sweep(0, -1, -1, 0, -1, -1, 0, -1, 50);
        checks++;
        if (timeout || busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_reach: to=%b busy=%b required 0/1", timeout, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (op_a !== '0 || op_b !== '0 || op_valid !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || pair_count !== 8'd0 || err_count !== 8'd0 || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL midreset_clear: op_a=%0d op_b=%0d v=%b busy=%b done=%b pc=%0d ec=%0d, required all 0",
                     op_a, op_b, op_valid, busy, done, pair_count, err_count);
        end
        done_seen = 0;
        repeat (3) begin @(posedge clk); #1; if (done) done_seen++; end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; if (done || busy) done_seen++; end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL midreset_quiet: %0d cycles with done/busy after reset, required 0", done_seen);
        end
        run_sweep(0, -1, -1, 0, -1, -1, 0, -1, -1);
        checks++;
        if (obs_q.size() == 0 || obs_q[0] !== {OP_W'(MIN_VAL), OP_W'(MIN_VAL)} ||
            obs_q.size() != exp_issue || fin_pc != 120) begin
            errors++;
            $display("FAIL midreset_restart: first=%h n=%0d pc=%0d required (1,1)/120/120",
                     obs_q.size() ? obs_q[0] : '0, obs_q.size(), fin_pc);
        end
    endtask

    task automatic test_random_handshake();
        int mism;
        build_model();
        for (int r = 0; r < 3; r++) begin
            run_sweep(1, -1, -1, 0, -1, -1, 0, -1, -1);
            mism = 0;
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
                if (obs_q[i] !== exp_q[i]) mism++;
            checks++;
            if (mism != 0 || obs_q.size() != exp_issue || fin_pc != 120 || fin_ec != 0 ||
                wait_bad || done_cnt != 1 || timeout) begin
                errors++;
                $display("FAIL random_run%0d: mism=%0d n=%0d pc=%0d ec=%0d wv=%b to=%b required 0/120/120/0/0/0",
                         r, mism, obs_q.size(), fin_pc, fin_ec, wait_bad, timeout);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_stall();
        test_bad_result();
        test_restart_ignored();
        test_reset_mid_sweep();
        test_random_handshake();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sub_operand_sequencer.md
SUB_OPERAND_SEQUENCER -- requirements
Module: sub_operand_sequencer

Interface
REQ-001 Parameter OP_W, default 5: operand width; the result width SHALL be OP_W+1.
REQ-002 Parameter MIN_VAL, default 1: first operand value of the sweep.
REQ-003 Parameter MAX_VAL, default 15: last operand value of the sweep.
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert and active-low.
REQ-006 start  in  1  level sampled in IDLE; begins one sweep.
REQ-007 op_a  out  OP_W  minuend presented to the downstream subtractor.
REQ-008 op_b  out  OP_W  subtrahend presented to the downstream subtractor.
REQ-009 op_valid  out  1  op_a/op_b valid.
REQ-010 op_ready  in  1  downstream accepts the pair.
REQ-011 res_d  in  OP_W+1  difference returned by the subtractor.
REQ-012 res_valid  in  1  res_d valid.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse at end of sweep.
REQ-015 pair_count  out  8  pairs accepted this sweep, saturating at 255.
REQ-016 err_count  out  8  result mismatches this sweep, saturating at 255.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE.
REQ-018 In IDLE with start=1, the block SHALL set a=MIN_VAL, b=MIN_VAL, clear both counters and enter ISSUE the next cycle.
REQ-019 In ISSUE with a>=b, op_valid SHALL be 1 with op_a=a and op_b=b.
REQ-020 In ISSUE with a<b, op_valid SHALL stay 0, the pair SHALL be skipped in one cycle, and the block SHALL advance per REQ-024.
REQ-021 A transfer SHALL occur on a cycle with op_valid&&op_ready; the block SHALL then increment pair_count and enter WAIT.
REQ-022 op_a/op_b SHALL stay stable while op_valid=1 and op_ready=0; op_valid SHALL NOT drop before the transfer.
REQ-023 In WAIT with res_valid=1, the block SHALL compare res_d to a-b (unsigned, zero-extended to OP_W+1), increment err_count on mismatch, then advance.
REQ-024 Advance rule: if b==MAX_VAL then b=MIN_VAL and a=a+1, else b=b+1.
REQ-025 When the advance starts from a==MAX_VAL and b==MAX_VAL, the block SHALL enter DONE instead of ISSUE.
REQ-026 In DONE, done SHALL be 1 for exactly one cycle, and the block SHALL enter IDLE the next cycle.
REQ-027 pair_count and err_count SHALL hold their values in IDLE until the next start.
REQ-028 The block SHALL ignore start while busy=1.
REQ-029 The block SHALL ignore res_valid outside WAIT.
REQ-030 In WAIT, op_valid SHALL be 0; only one pair SHALL be outstanding at a time.
REQ-031 With default parameters, one sweep SHALL issue exactly 120 pairs.
REQ-032 With op_ready and res_valid tied to 1, each issued pair SHALL take 2 cycles and each skipped pair 1 cycle.

Reset
REQ-033 While rst_n=0, the block SHALL immediately force: state=IDLE, op_a=0, op_b=0, op_valid=0, busy=0, done=0, pair_count=0, err_count=0, and internal a/b=0.
REQ-034 Reset mid-sweep SHALL abandon the sweep with no done pulse.
REQ-035 After rst_n returns to 1, the block SHALL need a new start.

Structure
REQ-036 Package sub_seq_pkg SHALL hold the FSM state enum and the default OP_W, MIN_VAL and MAX_VAL constants.
REQ-037 Sub-module sub_seq_checker SHALL own the expected-difference compare and the saturating err_count.
REQ-038 The top level SHALL own the FSM, the operand registers and pair_count.

Verification
REQ-039 Scenario: start=1, op_ready=1, model returns the correct a-b the cycle after transfer -> 120 transfers, first pair (1,1), last pair (15,15), pair_count=120, err_count=0, one done pulse.
REQ-040 Scenario: op_ready held 0 for 5 cycles on pair (4,2) -> op_a=4 and op_b=2 stay stable, op_valid stays 1, pair_count unchanged until op_ready=1.
REQ-041 Scenario: model returns 5 for pair (7,3) -> err_count=1 at done, pair_count=120.
REQ-042 Scenario: pulse start again at pair 10 -> the sweep is unaffected and ends at 120 pairs.
REQ-043 Scenario: rst_n=0 at pair 50 -> all outputs are 0 at once, no done pulse; a new start then restarts at (1,1).
REQ-044 Scenario: res_valid=1 with a wrong res_d during ISSUE -> err_count unchanged.
